up_down_counter: RTL and testbench
==================================

Name: up_down_counter

Overview:
- Synchronous WIDTH-bit binary up/down counter; default 4 bits.
- Counts up or down by one on every rising clock edge; direction comes from a single level-sensitive control input.
- Wraps modulo 2^WIDTH in both directions.
- General-purpose leaf block for sequencing, timers and address generation.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset; forces the counter to zero.
- up_down  input  1  direction select: 1 = count up (+1), 0 = count down (-1).
- counter  output  WIDTH  current count, driven directly from a register.
- Port order is exactly: clk, reset, up_down, counter. Optional ports are appended after counter.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high. No asynchronous paths.
- Reset:
  - reset=1 sampled at a rising edge sets counter to 0 on that edge.
  - Reset has priority over counting.
  - Asserting reset mid-count clears to 0 on the next edge, regardless of up_down.
- Counting, every rising edge with reset=0:
  - up_down=1: counter <= counter + 1 mod 2^WIDTH.
  - up_down=0: counter <= counter - 1 mod 2^WIDTH.
- No enable: the counter changes on every non-reset edge.
- Wrap-around (WIDTH=4):
  - up from 15 goes to 0.
  - down from 0 goes to 15.
  - No saturation and no error flag.
- Direction change takes effect on the first edge where the new up_down value is sampled. There is no extra latency and no hold state.
- Latency: one cycle from sampled inputs to the updated counter value. counter is a pure register output with no combinational path from inputs.
- Power-up value before the first reset is undefined. Consumers must apply reset.
- Arithmetic is unsigned, truncated to WIDTH bits.

Optional Feature:
- Macro: UP_DOWN_COUNTER_TC_EN.
- Defined: adds output port tc (1 bit, registered), appended after counter.
  - tc=1 in the cycle where the counter holds its terminal value for the current direction: all-ones when up_down=1, zero when up_down=0. tc is computed from the registered counter and registered direction.
  - tc=0 while reset is asserted and on the edge reset is applied.
- Not defined: no tc port and no tc logic. Counter behaviour is identical in both builds.

Decomposition:
- Package up_down_counter_pkg holds:
  - COUNT_UP = 1'b1 and COUNT_DOWN = 1'b0, direction encodings.
  - DEFAULT_WIDTH = 4.
  - A function computing the terminal value for a direction.
- Optional sub-module up_down_counter_tc, the terminal-count detector. It is instantiated only under UP_DOWN_COUNTER_TC_EN.
- The core counter register and next-state mux stay in the top module.

Test Plan:
- Reset hold: clk period 10 ns, reset=1 for 5 edges with up_down=0 -> counter=0 on every edge.
- Count down with wrap: release reset with up_down=0 -> counter sequence 15, 14, 13, 12, 11 on successive edges.
- Count up with wrap: from 11 set up_down=1 -> 12, 13, 14, 15, 0, 1.
- Direction reversal: at counter=5, toggle up_down each edge starting from 1 -> 6, 5, 6, 5.
- Reset mid-operation: at counter=9 counting up, assert reset for one edge -> 0; release -> 1.
- Optional build with UP_DOWN_COUNTER_TC_EN:
  - Counting up, tc=1 only while counter=15.
  - Counting down, tc=1 only while counter=0.
  - tc=0 during reset.

Source files
------------

// File: rtl/up_down_counter_pkg.sv
// Shared direction encodings, default width and terminal-value helper for up_down_counter.
package up_down_counter_pkg;

    localparam logic        COUNT_UP      = 1'b1;
    localparam logic        COUNT_DOWN    = 1'b0;
    localparam int          DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 32;

    // Value at which the counter is about to wrap for the given direction,
    // right-aligned in a MAX_WIDTH word; callers slice off their own width.
    function automatic logic [MAX_WIDTH-1:0] terminal_value(input logic dir,
                                                            input int unsigned width);
        logic [MAX_WIDTH-1:0] ones;
        ones = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
        return (dir == COUNT_UP) ? ones : '0;
    endfunction

endpackage

// File: rtl/up_down_counter_tc.sv
// Registered terminal-count flag; only instantiated when UP_DOWN_COUNTER_TC_EN is defined.
module up_down_counter_tc
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_down,
    input  logic [WIDTH-1:0] count_next,
    output logic             tc
);

    logic [MAX_WIDTH-1:0] term_full;
    logic [WIDTH-1:0]     term;

    // NOTE: assign every always_comb output before any branch so no latch is inferred.
    always_comb begin
        term_full = terminal_value(up_down, WIDTH);
        term      = term_full[WIDTH-1:0];
    end

    // Comparing the next count against the direction being sampled yields, after
    // the edge, exactly "registered counter equals terminal of registered direction".
    always_ff @(posedge clk) begin
        if (reset) begin
            tc <= 1'b0;
        end else begin
            tc <= (count_next == term);
        end
    end

endmodule

// File: rtl/up_down_counter.sv
// WIDTH-bit synchronous up/down counter with wrap-around in both directions.
// Optional terminal-count output tc is enabled by defining UP_DOWN_COUNTER_TC_EN.
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_down,
    output logic [WIDTH-1:0] counter
`ifdef UP_DOWN_COUNTER_TC_EN
    ,
    output logic             tc
`endif
);

    logic [WIDTH-1:0] count_next;

    // Unsigned WIDTH-bit arithmetic: truncation provides the modulo-2^WIDTH wrap.
    always_comb begin
        count_next = counter;
        if (up_down == COUNT_UP) begin
            count_next = counter + WIDTH'(1);
        end else begin
            count_next = counter - WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
        end else begin
            counter <= count_next;
        end
    end

`ifdef UP_DOWN_COUNTER_TC_EN
    up_down_counter_tc #(
        .WIDTH      (WIDTH)
    ) u_tc (
        .clk        (clk),
        .reset      (reset),
        .up_down    (up_down),
        .count_next (count_next),
        .tc         (tc)
    );
`endif

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter: directed test plan plus randomized
// traffic compared every cycle against an arithmetic model of the count.
module tb_up_down_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             up_down;
    logic [WIDTH-1:0] counter;
`ifdef UP_DOWN_COUNTER_TC_EN
    logic             tc;
`endif

    up_down_counter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .up_down (up_down),
        .counter (counter)
`ifdef UP_DOWN_COUNTER_TC_EN
        ,
        .tc      (tc)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the count as a plain integer, plus what the flag must be.
    int   model_count = 0;
    bit   model_valid = 1'b0;
    bit   model_tc    = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic step(input logic r, input logic ud);
        reset   = r;
        up_down = ud;
        @(posedge clk);
        #1;
        if (r) begin
            model_count = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            model_count = ud ? (model_count + 1) % MOD : (model_count + MOD - 1) % MOD;
        end
        model_tc = model_valid && !r && (model_count == (ud ? MOD - 1 : 0));
    endtask

    // Every-cycle comparison on the falling edge, once reset has defined the state.
    always @(negedge clk) begin
        if (model_valid) begin
            check("counter_vs_model", 32'(counter), 32'(model_count));
`ifdef UP_DOWN_COUNTER_TC_EN
            check("tc_vs_model", 32'(tc), 32'(model_tc));
`endif
        end
    end

    initial begin
        int down_seq [5] = '{15, 14, 13, 12, 11};
        int up_seq   [6] = '{12, 13, 14, 15, 0, 1};
        int rev_seq  [4] = '{6, 5, 6, 5};

        reset   = 1'b1;
        up_down = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            check("reset_hold", 32'(counter), 32'd0);
`ifdef UP_DOWN_COUNTER_TC_EN
            check("tc_in_reset", 32'(tc), 32'd0);
`endif
        end

        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            check("down_wrap", 32'(counter), 32'(down_seq[i]));
        end

        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1);
            check("up_wrap", 32'(counter), 32'(up_seq[i]));
`ifdef UP_DOWN_COUNTER_TC_EN
            check("tc_up", 32'(tc), (up_seq[i] == 15) ? 32'd1 : 32'd0);
`endif
        end

        // Count up from 1 to 5, then reverse direction every edge.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        check("reach_5", 32'(counter), 32'd5);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
            check("reversal", 32'(counter), 32'(rev_seq[i]));
        end

        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        check("reach_9", 32'(counter), 32'd9);
        step(1'b1, 1'b1);
        check("mid_reset", 32'(counter), 32'd0);
`ifdef UP_DOWN_COUNTER_TC_EN
        check("tc_mid_reset", 32'(tc), 32'd0);
`endif
        step(1'b0, 1'b1);
        check("after_reset", 32'(counter), 32'd1);

        // Count down through zero so the down-direction flag is exercised.
        step(1'b0, 1'b0);
        check("down_to_0", 32'(counter), 32'd0);
`ifdef UP_DOWN_COUNTER_TC_EN
        check("tc_down_at_0", 32'(tc), 32'd1);
`endif
        step(1'b0, 1'b0);
        check("down_to_15", 32'(counter), 32'd15);
`ifdef UP_DOWN_COUNTER_TC_EN
        check("tc_down_at_15", 32'(tc), 32'd0);
`endif

        // Randomized traffic: mostly counting, occasional resets, runs of one direction.
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic ud;
            r  = ($urandom_range(0, 29) == 0);
            ud = (i % 40 < 20) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            if (i % 100 >= 90) ud = $urandom_range(0, 1) == 1;
            step(r, ud);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
